// File: rtl/gaussian_stream_ctrl.sv
// gaussian_stream_ctrl: clock-enable gating, valid/bubble slot tagging and
// frame accounting around an external fixed-latency Gaussian blur core.
module gaussian_stream_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PIPE_LAT = 5,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic              clk,
  input  logic              global_reset_n,
  input  logic              start,
  input  logic              din_empty,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  input  logic              full,
  output logic              wr_en,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] core_din,
  output logic              core_clk_en,
  output logic              core_sreset,
  input  logic [DATA_W-1:0] core_dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [PIPE_LAT-1:0] tag_reg, tag_next, tag_shifted, tag_after;
  logic [CNT_W-1:0]    in_cnt_reg, in_cnt_next;
  logic [CNT_W-1:0]    out_cnt_reg, out_cnt_next;
  logic                in_run, in_drain, result_pending, advance;

  // Slot 0 receives "real pixel" only while popping upstream; DRAIN feeds bubbles.
  assign tag_shifted[0] = in_run;
  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag_shift
      assign tag_shifted[gi] = tag_reg[gi-1];
    end
  endgenerate

  // Handshake path: purely combinational from state, tags, din_empty and full.
  always_comb begin
    in_run         = (state_reg == RUN);
    in_drain       = (state_reg == DRAIN);
    result_pending = tag_reg[PIPE_LAT-1];
    // Only a real result at the core output can be blocked by a full FIFO;
    // bubbles are simply discarded, so they never stall the pipeline.
    advance        = ((in_run && !din_empty) || in_drain) && !(full && result_pending);
    tag_after      = advance ? tag_shifted : tag_reg;
    core_clk_en    = advance;
    rd_en          = advance && in_run;
    wr_en          = advance && result_pending;
    core_din       = in_run ? data_in : '0;
    core_sreset    = (state_reg == CLEAR);
    busy           = (state_reg != IDLE);
    frame_done     = (state_reg == DONE);
    data_out       = core_dout;
  end

  // Next-state, tag shifting and pixel counters.
  always_comb begin
    state_next   = state_reg;
    tag_next     = tag_reg;
    in_cnt_next  = in_cnt_reg;
    out_cnt_next = out_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        tag_next     = '0;
        in_cnt_next  = '0;
        out_cnt_next = '0;
        state_next   = RUN;
      end
      RUN: begin
        // The final pop still completes in this cycle; draining starts next.
        if (rd_en && (in_cnt_reg == LAST_IDX)) state_next = DRAIN;
      end
      DRAIN: begin
        // Leave only once no real result remains anywhere in the core.
        if (tag_after == '0) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (advance) tag_next = tag_shifted;
    if (rd_en) in_cnt_next = in_cnt_reg + CNT_W'(1);
    if (wr_en) out_cnt_next = out_cnt_reg + CNT_W'(1);
  end

  // State, tag and counter registers; reset may strike mid-frame.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_reg   <= IDLE;
      tag_reg     <= '0;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tag_reg     <= tag_next;
      in_cnt_reg  <= in_cnt_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// Bench for gaussian_stream_ctrl: table-driven directed frames on a 4x2
// instance, randomized stall frames on a 6x4 instance, with a behavioural
// core, an upstream FIFO head model and an in-order result scoreboard.
module tb_gaussian_stream_ctrl;

  localparam int DW = 8;
  localparam int PL = 3;

  typedef struct {
    bit empty;
    bit full;
    bit rd;
    bit wr;
    bit cen;
    bit srst;
    bit done;
    bit busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          global_reset_n;
  logic          start_a, start_b, din_empty, full;
  logic [DW-1:0] data_in;

  logic          rd_a, wr_a, cen_a, srst_a, busy_a, done_a;
  logic [DW-1:0] dout_a, cdin_a, cdout_a;
  logic          rd_b, wr_b, cen_b, srst_b, busy_b, done_b;
  logic [DW-1:0] dout_b, cdin_b, cdout_b;

  gaussian_stream_ctrl #(.DATA_W(DW), .PIPE_LAT(PL), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .global_reset_n(global_reset_n), .start(start_a),
    .din_empty(din_empty), .data_in(data_in), .rd_en(rd_a), .full(full),
    .wr_en(wr_a), .data_out(dout_a), .core_din(cdin_a), .core_clk_en(cen_a),
    .core_sreset(srst_a), .core_dout(cdout_a), .busy(busy_a), .frame_done(done_a)
  );

  gaussian_stream_ctrl #(.DATA_W(DW), .PIPE_LAT(PL), .IMG_W(6), .IMG_H(4)) dut_b (
    .clk(clk), .global_reset_n(global_reset_n), .start(start_b),
    .din_empty(din_empty), .data_in(data_in), .rd_en(rd_b), .full(full),
    .wr_en(wr_b), .data_out(dout_b), .core_din(cdin_b), .core_clk_en(cen_b),
    .core_sreset(srst_b), .core_dout(cdout_b), .busy(busy_b), .frame_done(done_b)
  );

  // Behavioural stand-in for the blur core: PL enabled stages then a fixed map.
  function automatic logic [DW-1:0] core_f(input logic [DW-1:0] x);
    return x * 8'd3 + 8'd7;
  endfunction

  logic [DW-1:0] pipe_a [PL];
  logic [DW-1:0] pipe_b [PL];

  // Core model for instance a
  always @(posedge clk) begin
    if (srst_a) begin
      for (int i = 0; i < PL; i++) pipe_a[i] <= '0;
    end else if (cen_a) begin
      pipe_a[0] <= cdin_a;
      for (int i = 1; i < PL; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  // Core model for instance b
  always @(posedge clk) begin
    if (srst_b) begin
      for (int i = 0; i < PL; i++) pipe_b[i] <= '0;
    end else if (cen_b) begin
      pipe_b[0] <= cdin_b;
      for (int i = 1; i < PL; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end

  assign cdout_a = core_f(pipe_a[PL-1]);
  assign cdout_b = core_f(pipe_b[PL-1]);

  // Observation mux: the instance under test
  logic          sel_b;
  logic          rd, wr, cen, srst, busy, done;
  logic [DW-1:0] dout, cdin;
  assign rd   = sel_b ? rd_b   : rd_a;
  assign wr   = sel_b ? wr_b   : wr_a;
  assign cen  = sel_b ? cen_b  : cen_a;
  assign srst = sel_b ? srst_b : srst_a;
  assign busy = sel_b ? busy_b : busy_a;
  assign done = sel_b ? done_b : done_a;
  assign dout = sel_b ? dout_b : dout_a;
  assign cdin = sel_b ? cdin_b : cdin_a;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  int            rd_cnt, wr_cnt, done_cnt;
  bit            popped;
  vec_t          tab [4][20];
  int            tab_len [4] = '{15, 18, 17, 16};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle strobes derived from the frame timing rules (4x2, latency 3).
  function automatic vec_t build(input int s, input int c);
    vec_t v;
    v = '{default: 0};
    case (s)
      0: begin // free stream
        v.rd = c inside {[2:9]};  v.wr = c inside {[5:12]};
        v.cen = c inside {[2:12]}; v.done = (c == 13); v.busy = c inside {[1:13]};
      end
      1: begin // downstream full in cycles 6-8
        v.full = c inside {[6:8]};
        v.rd = c inside {[2:5], [9:12]}; v.wr = c inside {5, [9:15]};
        v.cen = c inside {[2:5], [9:15]}; v.done = (c == 16); v.busy = c inside {[1:16]};
      end
      2: begin // upstream empty in cycles 3-4
        v.empty = c inside {3, 4};
        v.rd = c inside {2, [5:11]}; v.wr = c inside {[7:14]};
        v.cen = c inside {2, [5:14]}; v.done = (c == 15); v.busy = c inside {[1:15]};
      end
      default: begin // full coincides with the last pop while a result is pending
        v.full = (c == 9);
        v.rd = c inside {[2:8], 10}; v.wr = c inside {[5:8], [10:13]};
        v.cen = c inside {[2:8], [10:13]}; v.done = (c == 14); v.busy = c inside {[1:14]};
      end
    endcase
    v.srst = (c == 1);
    return v;
  endfunction

  task automatic clear_counts();
    exp_q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
  endtask

  // Per-cycle scoreboard and protocol rules; live enables the must-advance rules.
  task automatic monitor(input bit live, input int total);
    if (live) begin
      if (rd_cnt < total && !din_empty && !full) chk("must_pop", rd, 1);
      if (rd_cnt == total && wr_cnt < total && !full) chk("must_drain", cen, 1);
    end
    popped = rd;
    if (rd) begin
      chk("pop_needs_data", din_empty, 0);
      chk("core_din_is_head", cdin, data_in);
      chk("pop_advances_core", cen, 1);
      exp_q.push_back(core_f(data_in));
      rd_cnt++;
    end
    if (wr) begin
      chk("push_needs_room", full, 0);
      chk("push_advances_core", cen, 1);
      if (exp_q.size() == 0) begin
        chk("push_without_pixel", 0, 1);
      end else begin
        chk($sformatf("data_out_%0d", wr_cnt), dout, exp_q[0]);
        void'(exp_q.pop_front());
      end
      wr_cnt++;
    end
    if (done) begin
      chk("done_after_all_writes", wr_cnt, total);
      done_cnt++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (popped) data_in = DW'($urandom_range(0, 255));
  endtask

  task automatic run_scen(input int s, input int ncyc, input int extra_start);
    for (int c = 0; c < ncyc; c++) begin
      start_a   = (c == 0) || (c == extra_start);
      din_empty = tab[s][c].empty;
      full      = tab[s][c].full;
      @(negedge clk);
      chk($sformatf("s%0d_c%0d_rd", s, c), rd, tab[s][c].rd);
      chk($sformatf("s%0d_c%0d_wr", s, c), wr, tab[s][c].wr);
      chk($sformatf("s%0d_c%0d_cen", s, c), cen, tab[s][c].cen);
      chk($sformatf("s%0d_c%0d_srst", s, c), srst, tab[s][c].srst);
      chk($sformatf("s%0d_c%0d_done", s, c), done, tab[s][c].done);
      chk($sformatf("s%0d_c%0d_busy", s, c), busy, tab[s][c].busy);
      monitor(1'b0, 8);
      $display("scen %0d cycle %0d rd=%0b wr=%0b cen=%0b data_out=%0h", s, c, rd, wr, cen, dout);
      next_cycle();
    end
    start_a = 1'b0;
  endtask

  task automatic end_of_frame(input string tag, input int total);
    chk({tag, "_pops"}, rd_cnt, total);
    chk({tag, "_pushes"}, wr_cnt, total);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  task automatic random_frame(input int n);
    bit seen;
    int cyc;
    seen = 1'b0;
    sel_b = 1'b1;
    clear_counts();
    for (cyc = 0; cyc < 3000; cyc++) begin
      start_b   = (cyc == 0);
      din_empty = ($urandom_range(0, 3) == 0);
      full      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (cyc == 1) chk("rand_clear", srst, 1);
      if (seen) begin
        chk("rand_idle_after_done", busy, 0);
        popped = 1'b0;
        next_cycle();
        break;
      end
      monitor(cyc >= 2, 24);
      if (rd || wr) $display("rand %0d cycle %0d rd=%0b wr=%0b data_out=%0h", n, cyc, rd, wr, dout);
      if (done) seen = 1'b1;
      next_cycle();
    end
    start_b = 1'b0;
    end_of_frame($sformatf("rand%0d", n), 24);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 20; c++)
        tab[s][c] = build(s, c);

    sel_b = 1'b0;
    popped = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    din_empty = 1'b0;
    full = 1'b0;
    data_in = 8'h11;
    clear_counts();

    // Reset held with random inputs on both instances
    global_reset_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start_a   = 1'($urandom_range(0, 1));
      start_b   = 1'($urandom_range(0, 1));
      din_empty = 1'($urandom_range(0, 1));
      full      = 1'($urandom_range(0, 1));
      data_in   = DW'($urandom_range(0, 255));
      @(negedge clk);
      chk("reset_strobes_a", {rd_a, wr_a, cen_a, srst_a, busy_a, done_a}, 0);
      chk("reset_strobes_b", {rd_b, wr_b, cen_b, srst_b, busy_b, done_b}, 0);
      chk("reset_core_din_a", cdin_a, 0);
      chk("reset_core_din_b", cdin_b, 0);
      chk("reset_data_out_a", dout_a, cdout_a);
      $display("reset cycle %0d busy_a=%0b busy_b=%0b", c, busy_a, busy_b);
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    din_empty = 1'b0;
    full = 1'b0;
    global_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_without_start_a", busy_a, 0);
      chk("idle_without_start_b", busy_b, 0);
      @(posedge clk);
      #1;
    end

    // Directed frames on the 4x2 instance
    for (int s = 0; s < 4; s++) begin
      clear_counts();
      run_scen(s, tab_len[s], -1);
      end_of_frame($sformatf("scen%0d", s), 8);
    end

    // Ignored start at cycle 4, then reset strikes in cycle 7
    clear_counts();
    run_scen(0, 7, 4);
    global_reset_n = 1'b0;
    #1;
    chk("midreset_strobes", {rd_a, wr_a, cen_a, srst_a, busy_a, done_a}, 0);
    chk("midreset_core_din", cdin_a, 0);
    $display("mid-frame reset busy=%0b rd=%0b", busy_a, rd_a);
    @(posedge clk);
    #1;
    global_reset_n = 1'b1;
    popped = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", busy_a, 0);
    @(posedge clk);
    #1;
    clear_counts();
    run_scen(0, tab_len[0], -1);
    end_of_frame("restart", 8);

    // Randomized stalls on the 6x4 instance
    for (int n = 0; n < 3; n++) random_frame(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
